rem_recon: RTL



---
 rtl/rem_recon.sv | 115 +++++++++++
 1 files changed

// File: rtl/rem_recon.sv
// Rebuilds a dividend as q*b+r. Shift-add multiply, then one add; done after edge WIDTH+2, one request per WIDTH+3 cycles.
// start is taken only in IDLE and ignored while busy (no queuing); REM_RECON_CHECK_EN enables the err operand check.
module rem_recon #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] a_out,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   q_sh;
  logic [WIDTH-1:0]   r_r;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL:     if (last_bit) state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Widest possible result is 2^(2W) - 2^W, so this sum never carries out.
  assign acc_sum = acc + {{WIDTH{1'b0}}, r_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sh  <= '0;
      r_r   <= '0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            q_sh  <= q;
            r_r   <= r;
            mcand <= {{WIDTH{1'b0}}, b};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        MUL: begin
          // mcand always holds b << cnt; q_sh[0] is the current multiplier bit.
          if (q_sh[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          q_sh  <= q_sh >> 1;
          cnt   <= cnt + 1'b1;
        end
        ADD: begin
          acc   <= acc_sum;
          a_out <= acc_sum;
          done  <= 1'b1;
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef REM_RECON_CHECK_EN
  logic chk_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_r <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept)       chk_r <= (b == '0) || (r >= b);
      if (state == ADD) err   <= chk_r;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
